// File: rtl/dec_pkg.sv
// Shared types and constants for the dec_scan one-hot select decoder.
package dec_pkg;

    typedef enum logic {
        DEC_DIRECT = 1'b0,
        DEC_SCAN   = 1'b1
    } dec_mode_e;

    // ST_IDLE: out of reset, nothing lit yet; ST_RUN: normal; ST_BLANK: gap cycle between scan indices
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BLANK = 2'd2
    } dec_state_e;

    // Replicated to the output width for the blank/disabled pattern
    localparam bit DEC_OFF = 1'b0;

endpackage

// File: rtl/dec_scan_if.sv
// Control and select bus of dec_scan; master drives mode/index/dwell, slave returns the registered select.
// Handshake: none; every input is sampled on each rising clk edge and every output is valid after it.
interface dec_scan_if #(
    parameter int IN_W    = 3,
    parameter int PRESC_W = 4
);
    import dec_pkg::*;

    localparam int OUT_W = 2**IN_W;

    logic               en;
    dec_mode_e          mode;
    logic [IN_W-1:0]    i;
    logic [PRESC_W-1:0] dwell;
    logic [OUT_W-1:0]   o;
    logic [IN_W-1:0]    idx;
    logic               wrap;
    dec_state_e         dbg_state;

    modport master (
        output en, mode, i, dwell,
        input  o, idx, wrap, dbg_state
    );

    modport slave (
        input  en, mode, i, dwell,
        output o, idx, wrap, dbg_state
    );

endinterface

// File: rtl/dec_onehot.sv
// Combinational binary-to-one-hot decode: o_out = 1 << i_in.
module dec_onehot #(
    parameter int IN_W = 3
) (
    input  logic [IN_W-1:0]      i_in,
    output logic [2**IN_W-1:0]   o_out
);
    localparam int OUT_W = 2**IN_W;

    assign o_out = OUT_W'(1) << i_in;

endmodule

// File: rtl/dec_scan.sv
// Registered N-to-2^N one-hot decoder with direct and dwell-counted scan modes.
// Optional macro DEC_SCAN_BLANK_EN inserts one dark cycle at every scan advance.
module dec_scan
    import dec_pkg::*;
#(
    parameter int IN_W    = 3,
    parameter int LAST    = 2**IN_W-1,
    parameter int PRESC_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    dec_scan_if.slave   io_bus
);
    localparam int OUT_W = 2**IN_W;

    if (LAST > OUT_W-1 || LAST < 0) begin : g_last_chk
        $error("dec_scan: LAST must lie in 0 .. 2**IN_W-1");
    end

    localparam logic [IN_W-1:0] LAST_IDX = IN_W'(LAST);

    dec_state_e         r_state, w_state_nxt;
    logic [IN_W-1:0]    r_idx, w_idx_nxt;
    logic [PRESC_W-1:0] r_cnt, w_cnt_nxt;
    logic [OUT_W-1:0]   r_o, w_o_nxt;
    logic               r_wrap, w_wrap_nxt;
    logic               w_show;
    logic [OUT_W-1:0]   w_onehot;

    dec_onehot #(.IN_W(IN_W)) u_onehot (
        .i_in  (w_idx_nxt),
        .o_out (w_onehot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_o     <= {OUT_W{DEC_OFF}};
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_o     <= w_o_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_wrap_nxt  = 1'b0;
        w_show      = 1'b0;
        if (io_bus.en) begin
            w_show = 1'b1;
            if (io_bus.mode == DEC_DIRECT) begin
                w_idx_nxt   = io_bus.i;
                w_cnt_nxt   = '0;
                w_state_nxt = ST_RUN;
            end else begin
                case (r_state)
                    // First enabled cycle after reset lights the current index and starts its full dwell
                    ST_IDLE: begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_RUN;
                    end
                    // idx already advanced during the blank; counter is 0, so the new index gets a full dwell
                    ST_BLANK: begin
                        w_state_nxt = ST_RUN;
                    end
                    default: begin
                        if (r_cnt >= io_bus.dwell) begin
                            w_cnt_nxt = '0;
                            if (r_idx >= LAST_IDX) begin
                                w_idx_nxt  = '0;
                                w_wrap_nxt = 1'b1;
                            end else begin
                                w_idx_nxt = r_idx + IN_W'(1);
                            end
`ifdef DEC_SCAN_BLANK_EN
                            w_show      = 1'b0;
                            w_state_nxt = ST_BLANK;
`endif
                        end else begin
                            w_cnt_nxt = r_cnt + PRESC_W'(1);
                        end
                    end
                endcase
            end
        end
        w_o_nxt = w_show ? w_onehot : {OUT_W{DEC_OFF}};
    end

    assign io_bus.o         = r_o;
    assign io_bus.idx       = r_idx;
    assign io_bus.wrap      = r_wrap;
    assign io_bus.dbg_state = r_state;

endmodule
